subservient_wb_timer: RTL and testbench
=======================================

Name: subservient_wb_timer

Overview:
Wishbone responder peripheral for the subservient SoC peripheral (extension) bus. It answers single accesses from the core's o_wb_* initiator port. It holds a prescaled 32-bit free-running counter, a compare register, control and status. It drives the timer interrupt that feeds the core's i_timer_irq input.

Parameters:
PRESCALE_W, 8, width of prescaler divisor field and prescaler counter (1..16)
RESET_CMP, 32'hFFFF_FFFF, reset value of MTIMECMP

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_wb_adr  in  2  word address, bits [3:2] of the bus address
i_wb_dat  in  32  write data
i_wb_sel  in  4  byte enables, bit n enables dat[8n+7:8n]
i_wb_we  in  1  write strobe qualifier
i_wb_stb  in  1  request; held by the initiator until ack
o_wb_rdt  out  32  read data, valid while o_wb_ack=1
o_wb_ack  out  1  one-cycle acknowledge
o_timer_irq  out  1  interrupt to the core, registered level

Behaviour:
- Register map by i_wb_adr:
  - 0: MTIME (rw).
  - 1: MTIMECMP (rw).
  - 2: CTRL (rw). [0] EN, [1] IRQ_EN, [2] AUTO_RELOAD, [8+PRESCALE_W-1:8] DIV. Other bits read 0.
  - 3: STATUS. [0] PEND, write-1-to-clear. Other bits read 0, writes ignored.
- Reset (async, i_rst_n=0): MTIME=0, MTIMECMP=RESET_CMP, CTRL=0, PEND=0, prescaler count=0, o_wb_ack=0, o_wb_rdt=0, o_timer_irq=0.
- Handshake:
  - Classic single access, no cyc and no burst.
  - Ack is registered. The cycle after stb=1 with ack=0, o_wb_ack=1 for exactly one cycle.
  - Fixed latency 1; no wait states.
  - stb is ignored in any cycle where o_wb_ack=1, so a held stb yields one ack only.
  - A back-to-back request is serviced every 2 cycles.
- Write: applied at the clock edge that raises ack. Only bytes with sel=1 are updated; sel=0 is a no-op write but still acked.
- Read:
  - o_wb_rdt is registered with ack and holds the register value as of the request cycle.
  - When ack=0, o_wb_rdt=0.
  - Reads have no side effects.
- Prescaler:
  - While EN=1, the prescaler counts 0..DIV; tick=1 when count==DIV, then count returns to 0.
  - DIV=0 gives a tick every cycle.
  - While EN=0, the prescaler and MTIME hold.
  - Any CTRL write clears the prescaler count.
- Counter: on tick, MTIME<=MTIME+1, wrapping mod 2^32.
- Match:
  - A match occurs when a tick produces next MTIME==MTIMECMP.
  - On match, PEND<=1.
  - If AUTO_RELOAD=1, MTIME<=0 instead of MTIMECMP.
- Simultaneous events:
  - A bus write to MTIME in the same cycle as a tick: the write wins, and no match is evaluated that cycle.
  - A write to MTIMECMP clears PEND.
  - A STATUS W1C in the same cycle as a new match: the set wins, so PEND=1.
- IRQ: o_timer_irq <= PEND & IRQ_EN, registered, so it follows PEND one cycle later. Clearing IRQ_EN deasserts the irq without clearing PEND.
- Reset mid-access: ack and rdt drop immediately. The initiator must reissue the access.

Decomposition:
- Shared package subservient_timer_pkg:
  - register index constants REG_MTIME=0, REG_MTIMECMP=1, REG_CTRL=2, REG_STATUS=3
  - CTRL bit positions (CTRL_EN, CTRL_IRQ_EN, CTRL_AUTO_RELOAD, CTRL_DIV_LSB)
  - a byte-masked write helper function
- One natural sub-module: subservient_timer_prescaler. Inputs are clock, reset, enable, clear and div; output is tick.

Test Plan:
- Reset then read all four registers -> rdt 0, 0xFFFFFFFF, 0, 0; each ack high for exactly one cycle, one cycle after stb.
- Write MTIME=0x12345678 with sel=4'b0101 -> readback 0x00340078; held stb over 4 cycles -> exactly 2 acks (stb re-sampled after ack drop).
- CTRL=EN|IRQ_EN with DIV=0, MTIMECMP=10 -> PEND=1 on the tick where MTIME reaches 10, o_timer_irq=1 one cycle later; STATUS write 1 -> PEND=0 and irq=0 one cycle after.
- DIV=3, EN=1 -> MTIME increments every 4th cycle. MTIME=0xFFFFFFFF wraps to 0 with no match when MTIMECMP=5.
- AUTO_RELOAD=1, MTIMECMP=3, DIV=0 -> MTIME sequence 1,2,0,1,2,0; PEND set at each reload. A W1C coincident with a match -> PEND stays 1.
- Assert i_rst_n=0 during an acked read and while irq=1 -> ack, rdt and irq go 0 asynchronously; after release, registers are back at reset values.

Source files
------------

// File: rtl/subservient_timer_pkg.sv
// ---------------------------------------------------------------------------
// subservient_timer_pkg
// Shared definitions for the subservient Wishbone timer peripheral:
//   - register indices on the 2-bit word address
//   - CTRL / STATUS bit positions
//   - byte_merge(): applies a Wishbone byte-enable mask to a 32-bit register
// ---------------------------------------------------------------------------
package subservient_timer_pkg;

    localparam logic [1:0] REG_MTIME    = 2'd0;
    localparam logic [1:0] REG_MTIMECMP = 2'd1;
    localparam logic [1:0] REG_CTRL     = 2'd2;
    localparam logic [1:0] REG_STATUS   = 2'd3;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_IRQ_EN      = 1;
    localparam int CTRL_AUTO_RELOAD = 2;
    localparam int CTRL_DIV_LSB     = 8;

    localparam int STATUS_PEND      = 0;

    // Lane n of the result takes wdat when sel[n]=1, otherwise keeps old_val.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdat,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = wdat[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/subservient_timer_prescaler.sv
// ---------------------------------------------------------------------------
// subservient_timer_prescaler
// Divides the clock by (div+1) while enabled. The count runs 0..div and
// tick is high in the cycle where count==div.
// Ports:
//   clk   in  clock
//   rst_n in  asynchronous active-low reset
//   en    in  count enable; count holds while low
//   clr   in  synchronous clear of the count (takes priority)
//   div   in  divisor, PRESCALE_W bits
//   tick  out one-cycle pulse every div+1 enabled cycles
// ---------------------------------------------------------------------------
module subservient_timer_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] count_reg;
    logic [PRESCALE_W-1:0] count_next;

    // Combinational so the counter sees the tick in the same cycle; div can
    // only change together with clr, so count never overshoots div.
    assign tick = en && (count_reg == div);

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (tick) begin
            count_next = '0;
        end else if (en) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/subservient_wb_timer.sv
// ---------------------------------------------------------------------------
// subservient_wb_timer
// Wishbone responder timer for the subservient SoC extension bus: a
// prescaled 32-bit MTIME counter, MTIMECMP compare, CTRL and STATUS, and a
// registered timer interrupt for the core.
// Ports:
//   i_clk        in  clock
//   i_rst_n      in  asynchronous active-low reset
//   i_wb_adr     in  [1:0]  word address (bus address bits [3:2])
//   i_wb_dat     in  [31:0] write data
//   i_wb_sel     in  [3:0]  byte enables
//   i_wb_we      in  write qualifier
//   i_wb_stb     in  request, held until ack
//   o_wb_rdt     out [31:0] read data, valid with ack, 0 otherwise
//   o_wb_ack     out one-cycle registered acknowledge
//   o_timer_irq  out registered PEND & IRQ_EN
// ---------------------------------------------------------------------------
module subservient_wb_timer
    import subservient_timer_pkg::*;
#(
    parameter int          PRESCALE_W = 8,
    parameter logic [31:0] RESET_CMP  = 32'hFFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_timer_irq
);

    logic [31:0]           mtime_reg,    mtime_next;
    logic [31:0]           mtimecmp_reg, mtimecmp_next;
    logic                  en_reg,       en_next;
    logic                  irq_en_reg,   irq_en_next;
    logic                  auto_rld_reg, auto_rld_next;
    logic [PRESCALE_W-1:0] div_reg,      div_next;
    logic                  pend_reg,     pend_next;
    logic                  ack_reg;
    logic [31:0]           rdt_reg,      rdt_next;
    logic                  irq_reg;

    logic        req;
    logic        wr_mtime;
    logic        wr_mtimecmp;
    logic        wr_ctrl;
    logic        wr_status;
    logic        tick;
    logic        match;
    logic [31:0] mtime_inc;
    logic [31:0] ctrl_word;
    logic [31:0] status_word;

    // A request is only taken while ack is low, so a held stb is acked once
    // and then re-sampled after ack drops.
    assign req         = i_wb_stb && !ack_reg;
    assign wr_mtime    = req && i_wb_we && (i_wb_adr == REG_MTIME);
    assign wr_mtimecmp = req && i_wb_we && (i_wb_adr == REG_MTIMECMP);
    assign wr_ctrl     = req && i_wb_we && (i_wb_adr == REG_CTRL);
    assign wr_status   = req && i_wb_we && (i_wb_adr == REG_STATUS);

    always_comb begin
        ctrl_word                                 = '0;
        ctrl_word[CTRL_EN]                        = en_reg;
        ctrl_word[CTRL_IRQ_EN]                    = irq_en_reg;
        ctrl_word[CTRL_AUTO_RELOAD]               = auto_rld_reg;
        ctrl_word[CTRL_DIV_LSB +: PRESCALE_W]     = div_reg;
        status_word                               = '0;
        status_word[STATUS_PEND]                  = pend_reg;
    end

    subservient_timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (en_reg),
        .clr   (wr_ctrl),
        .div   (div_reg),
        .tick  (tick)
    );

    assign mtime_inc = mtime_reg + 32'd1;
    // A bus write to MTIME overrides the tick, so no match is taken then.
    assign match     = tick && !wr_mtime && (mtime_inc == mtimecmp_reg);

    // Single-bit CTRL fields all live in byte lane 0.
    always_comb begin
        en_next       = en_reg;
        irq_en_next   = irq_en_reg;
        auto_rld_next = auto_rld_reg;
        if (wr_ctrl && i_wb_sel[0]) begin
            en_next       = i_wb_dat[CTRL_EN];
            irq_en_next   = i_wb_dat[CTRL_IRQ_EN];
            auto_rld_next = i_wb_dat[CTRL_AUTO_RELOAD];
        end
    end

    // DIV may straddle byte lanes 1 and 2, so each bit follows its own lane.
    generate
        for (genvar gi = 0; gi < PRESCALE_W; gi++) begin : g_div
            assign div_next[gi] = (wr_ctrl && i_wb_sel[(CTRL_DIV_LSB + gi) / 8])
                                ? i_wb_dat[CTRL_DIV_LSB + gi] : div_reg[gi];
        end
    endgenerate

    always_comb begin
        mtime_next    = mtime_reg;
        mtimecmp_next = mtimecmp_reg;
        pend_next     = pend_reg;

        if (wr_mtime) begin
            mtime_next = byte_merge(mtime_reg, i_wb_dat, i_wb_sel);
        end else if (tick) begin
            mtime_next = (match && auto_rld_reg) ? 32'd0 : mtime_inc;
        end

        if (wr_mtimecmp) begin
            mtimecmp_next = byte_merge(mtimecmp_reg, i_wb_dat, i_wb_sel);
            pend_next     = 1'b0;
        end

        if (wr_status && i_wb_sel[0] && i_wb_dat[STATUS_PEND]) begin
            pend_next = 1'b0;
        end

        // Setting beats any clear arriving in the same cycle.
        if (match) begin
            pend_next = 1'b1;
        end
    end

    always_comb begin
        rdt_next = '0;
        if (req) begin
            case (i_wb_adr)
                REG_MTIME:    rdt_next = mtime_reg;
                REG_MTIMECMP: rdt_next = mtimecmp_reg;
                REG_CTRL:     rdt_next = ctrl_word;
                default:      rdt_next = status_word;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtime_reg    <= '0;
            mtimecmp_reg <= RESET_CMP;
            en_reg       <= 1'b0;
            irq_en_reg   <= 1'b0;
            auto_rld_reg <= 1'b0;
            div_reg      <= '0;
            pend_reg     <= 1'b0;
            ack_reg      <= 1'b0;
            rdt_reg      <= '0;
            irq_reg      <= 1'b0;
        end else begin
            mtime_reg    <= mtime_next;
            mtimecmp_reg <= mtimecmp_next;
            en_reg       <= en_next;
            irq_en_reg   <= irq_en_next;
            auto_rld_reg <= auto_rld_next;
            div_reg      <= div_next;
            pend_reg     <= pend_next;
            ack_reg      <= req;
            rdt_reg      <= rdt_next;
            irq_reg      <= pend_reg && irq_en_reg;
        end
    end

    assign o_wb_ack    = ack_reg;
    assign o_wb_rdt    = rdt_reg;
    assign o_timer_irq = irq_reg;

endmodule

// File: tb/tb_subservient_wb_timer.sv
// ---------------------------------------------------------------------------
// tb_subservient_wb_timer
// Directed bench for subservient_wb_timer. Inputs change on the falling
// edge; outputs are sampled on the falling edge (or 1 time unit after a
// rising edge). Expected read data is queued when a read is issued and
// popped when the acknowledge arrives.
// ---------------------------------------------------------------------------
module tb_subservient_wb_timer;

    logic        i_clk    = 1'b0;
    logic        i_rst_n  = 1'b0;
    logic [1:0]  i_wb_adr = '0;
    logic [31:0] i_wb_dat = '0;
    logic [3:0]  i_wb_sel = '0;
    logic        i_wb_we  = 1'b0;
    logic        i_wb_stb = 1'b0;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;
    logic        o_timer_irq;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];

    always #5 i_clk = ~i_clk;

    subservient_wb_timer #(
        .PRESCALE_W (8),
        .RESET_CMP  (32'hFFFF_FFFF)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wb_adr    (i_wb_adr),
        .i_wb_dat    (i_wb_dat),
        .i_wb_sel    (i_wb_sel),
        .i_wb_we     (i_wb_we),
        .i_wb_stb    (i_wb_stb),
        .o_wb_rdt    (o_wb_rdt),
        .o_wb_ack    (o_wb_ack),
        .o_timer_irq (o_timer_irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        $display("vec %0d %s observed=0x%08h expected=0x%08h", vectors, tag, obs, exp);
    endtask

    // One access: stb for one cycle, ack expected at the next falling edge,
    // then one idle cycle in which ack and rdt must be low.
    task automatic bus(input logic [1:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we, input string tag);
        logic [31:0] exp;
        i_wb_adr = adr;
        i_wb_dat = dat;
        i_wb_sel = sel;
        i_wb_we  = we;
        i_wb_stb = 1'b1;
        @(negedge i_clk);
        check({tag, "_ack"}, {31'b0, o_wb_ack}, 32'd1);
        if (!we) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
            end else begin
                exp = exp_q.pop_front();
                check(tag, o_wb_rdt, exp);
            end
        end
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        @(negedge i_clk);
        check({tag, "_ack_drop"}, {31'b0, o_wb_ack}, 32'd0);
        check({tag, "_rdt_idle"}, o_wb_rdt, 32'd0);
    endtask

    task automatic rd(input logic [1:0] adr, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        bus(adr, 32'd0, 4'h0, 1'b0, tag);
    endtask

    task automatic wr(input logic [1:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input string tag);
        bus(adr, dat, sel, 1'b1, tag);
    endtask

    initial begin
        int acks;

        // Reset state
        repeat (2) @(negedge i_clk);
        check("rst_ack", {31'b0, o_wb_ack}, 32'd0);
        check("rst_irq", {31'b0, o_timer_irq}, 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        rd(2'd0, 32'h0000_0000, "rst_mtime");
        rd(2'd1, 32'hFFFF_FFFF, "rst_mtimecmp");
        rd(2'd2, 32'h0000_0000, "rst_ctrl");
        rd(2'd3, 32'h0000_0000, "rst_status");

        // Byte-masked write and held stb
        wr(2'd0, 32'h1234_5678, 4'b0101, "wr_mtime_sel5");
        rd(2'd0, 32'h0034_0078, "mtime_sel5");
        i_wb_adr = 2'd0;
        i_wb_we  = 1'b0;
        i_wb_stb = 1'b1;
        acks     = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            if (o_wb_ack) begin
                acks++;
                check("held_rdt", o_wb_rdt, 32'h0034_0078);
            end
        end
        i_wb_stb = 1'b0;
        check("held_acks", acks, 32'd2);

        // CTRL field layout, sel=0 no-op
        wr(2'd2, 32'hFFFF_FFFF, 4'h0, "wr_ctrl_sel0");
        rd(2'd2, 32'h0000_0000, "ctrl_sel0");
        wr(2'd2, 32'hFFFF_FFFF, 4'hF, "wr_ctrl_all");
        rd(2'd2, 32'h0000_FF07, "ctrl_all");
        wr(2'd2, 32'h0000_0000, 4'hF, "wr_ctrl_off");
        rd(2'd0, 32'h0034_0078, "mtime_hold");

        // Match with DIV=0, irq and W1C
        wr(2'd0, 32'd0,  4'hF, "wr_mtime0");
        wr(2'd1, 32'd10, 4'hF, "wr_cmp10");
        wr(2'd2, 32'h3,  4'hF, "wr_ctrl_en_ie");
        repeat (8) @(negedge i_clk);
        check("irq_before_match", {31'b0, o_timer_irq}, 32'd0);
        rd(2'd3, 32'd0, "pend_before_match");
        check("irq_after_match", {31'b0, o_timer_irq}, 32'd1);
        rd(2'd3, 32'd1, "pend_after_match");
        wr(2'd3, 32'd1, 4'h1, "w1c_pend");
        check("irq_after_w1c", {31'b0, o_timer_irq}, 32'd0);
        rd(2'd3, 32'd0, "pend_after_w1c");
        wr(2'd2, 32'd0, 4'hF, "wr_ctrl_stop1");

        // DIV=3: one increment every 4 cycles
        wr(2'd0, 32'd0, 4'hF, "wr_mtime0_div");
        wr(2'd2, 32'h301, 4'hF, "wr_ctrl_div3");
        repeat (4) @(negedge i_clk);
        rd(2'd0, 32'd1, "div3_mtime1");
        repeat (2) @(negedge i_clk);
        rd(2'd0, 32'd2, "div3_mtime2");
        repeat (2) @(negedge i_clk);
        rd(2'd0, 32'd3, "div3_mtime3");
        wr(2'd2, 32'd0, 4'hF, "wr_ctrl_stop2");

        // Wrap with no match
        wr(2'd1, 32'd5, 4'hF, "wr_cmp5");
        wr(2'd0, 32'hFFFF_FFFF, 4'hF, "wr_mtime_max");
        wr(2'd2, 32'h1, 4'hF, "wr_ctrl_en");
        rd(2'd0, 32'd0, "wrap_mtime");
        rd(2'd3, 32'd0, "wrap_no_pend");
        wr(2'd2, 32'd0, 4'hF, "wr_ctrl_stop3");

        // Auto reload with MTIMECMP=3: MTIME 1,2,0,...
        wr(2'd0, 32'd0, 4'hF, "wr_mtime0_ar");
        wr(2'd1, 32'd3, 4'hF, "wr_cmp3");
        wr(2'd2, 32'h7, 4'hF, "wr_ctrl_ar");
        rd(2'd0, 32'd1, "ar_mtime_a");
        rd(2'd0, 32'd0, "ar_mtime_b");
        rd(2'd0, 32'd2, "ar_mtime_c");
        rd(2'd0, 32'd1, "ar_mtime_d");
        rd(2'd0, 32'd0, "ar_mtime_e");
        rd(2'd3, 32'd1, "ar_pend");
        @(negedge i_clk);
        wr(2'd3, 32'd1, 4'h1, "w1c_coincident");
        rd(2'd3, 32'd1, "pend_set_wins");
        wr(2'd3, 32'd1, 4'h1, "w1c_between");
        rd(2'd3, 32'd0, "pend_cleared");
        check("ar_irq", {31'b0, o_timer_irq}, 32'd1);

        // Asynchronous reset during an acked read with irq high
        i_wb_adr = 2'd1;
        i_wb_we  = 1'b0;
        i_wb_stb = 1'b1;
        @(posedge i_clk);
        #1;
        check("pre_rst_ack", {31'b0, o_wb_ack}, 32'd1);
        check("pre_rst_rdt", o_wb_rdt, 32'd3);
        check("pre_rst_irq", {31'b0, o_timer_irq}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        check("async_rst_ack", {31'b0, o_wb_ack}, 32'd0);
        check("async_rst_rdt", o_wb_rdt, 32'd0);
        check("async_rst_irq", {31'b0, o_timer_irq}, 32'd0);
        i_wb_stb = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        rd(2'd0, 32'h0000_0000, "rst2_mtime");
        rd(2'd1, 32'hFFFF_FFFF, "rst2_mtimecmp");
        rd(2'd2, 32'h0000_0000, "rst2_ctrl");
        rd(2'd3, 32'h0000_0000, "rst2_status");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
